fpu_mul16_sig_iter: RTL and testbench



---
 rtl/fpu_mul16_sig_iter.sv | 229 ++++++++++++++++++++++
 tb/tb_fpu_mul16_sig_iter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_mul16_sig_iter.sv
// FP16 multiply front end: iterative shift-add significand product with exponent
// and special-operand handling, emitted in the unnormalized layout of the normalizer.
//
// state | meaning
// IDLE  | waiting for operands, inReady high
// BUSY  | shift-add iterations, STEP multiplier bits consumed per cycle
// DONE  | first cycle registers the result, then outValid held until outReady

module fpu_mul16_sig_iter #(
    parameter int STEP = 1,
    parameter int PFW  = 20
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           inValid,
    output logic           inReady,
    input  logic [15:0]    opA,
    input  logic [15:0]    opB,
    output logic           outValid,
    input  logic           outReady,
    output logic           unnormSign,
    output logic [1:0]     unnormInt,
    output logic [PFW-1:0] unnormFrac,
    output logic [4:0]     unnormExp,
    output logic [9:0]     denormDiff,
    output logic           sticky,
    output logic           OFin,
    output logic           isNaN,
    output logic           isInf
);

    localparam int N  = (11 + STEP - 1) / STEP;
    localparam int MW = N * STEP;
    localparam int CW = 4;

    generate
        if (STEP != 1 && STEP != 2) begin : g_bad_step
            $error("fpu_mul16_sig_iter: STEP must be 1 or 2");
        end
        if (PFW != 20) begin : g_bad_pfw
            $error("fpu_mul16_sig_iter: PFW must be 20");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [15:0]     opa_q;
    logic [15:0]     opb_q;
    logic [21:0]     acc_q;
    logic [21:0]     mcand_q;
    logic [MW-1:0]   mplier_q;

    logic            in_ready_q;
    logic            out_valid_q;
    logic            sign_q;
    logic [1:0]      int_q;
    logic [PFW-1:0]  frac_q;
    logic [4:0]      exp_q;
    logic [9:0]      dd_q;
    logic            of_q;
    logic            nan_q;
    logic            inf_q;

    // Zero, infinity and NaN all bypass the iterative datapath.
    function automatic logic is_fast(input logic [15:0] x);
        return (x[14:10] == 5'h1f) || (x[14:0] == 15'd0);
    endfunction

    logic [10:0] sig_a_in;
    logic [10:0] sig_b_in;

    assign sig_a_in = {opA[14:10] != 5'd0, opA[9:0]};
    assign sig_b_in = {opB[14:10] != 5'd0, opB[9:0]};

    logic [21:0] pp;

    always_comb begin
        pp = '0;
        for (int i = 0; i < STEP; i++) begin
            if (mplier_q[i]) begin
                pp = pp + (mcand_q << i);
            end
        end
    end

    logic            a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [4:0]      ea, eb;
    logic signed [6:0] exp_sum;
    logic [6:0]      neg_sum;

    logic            res_sign_d;
    logic [1:0]      res_int_d;
    logic [PFW-1:0]  res_frac_d;
    logic [4:0]      res_exp_d;
    logic [9:0]      res_dd_d;
    logic            res_of_d;
    logic            res_nan_d;
    logic            res_inf_d;

    always_comb begin
        a_zero  = (opa_q[14:0] == 15'd0);
        b_zero  = (opb_q[14:0] == 15'd0);
        a_inf   = (opa_q[14:10] == 5'h1f) && (opa_q[9:0] == 10'd0);
        b_inf   = (opb_q[14:10] == 5'h1f) && (opb_q[9:0] == 10'd0);
        a_nan   = (opa_q[14:10] == 5'h1f) && (opa_q[9:0] != 10'd0);
        b_nan   = (opb_q[14:10] == 5'h1f) && (opb_q[9:0] != 10'd0);
        ea      = (opa_q[14:10] == 5'd0) ? 5'd1 : opa_q[14:10];
        eb      = (opb_q[14:10] == 5'd0) ? 5'd1 : opb_q[14:10];
        exp_sum = 7'(ea) + 7'(eb) - 7'd15;
        neg_sum = 7'(-exp_sum);

        res_sign_d = opa_q[15] ^ opb_q[15];
        res_int_d  = acc_q[21:20];
        res_frac_d = acc_q[PFW-1:0];
        res_exp_d  = '0;
        res_dd_d   = '0;
        res_of_d   = 1'b0;
        res_nan_d  = 1'b0;
        res_inf_d  = 1'b0;

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            res_nan_d  = 1'b1;
            res_sign_d = 1'b0;
            res_int_d  = '0;
            res_frac_d = '0;
        end else if (a_inf || b_inf) begin
            res_inf_d  = 1'b1;
            res_of_d   = 1'b1;
            res_int_d  = '0;
            res_frac_d = '0;
        end else if (a_zero || b_zero) begin
            res_int_d  = '0;
            res_frac_d = '0;
        end else if (exp_sum >= 7'sd31) begin
            res_of_d   = 1'b1;
            res_int_d  = '0;
            res_frac_d = '0;
        end else if (exp_sum >= 7'sd1) begin
            res_exp_d  = exp_sum[4:0];
        end else begin
            res_dd_d   = (neg_sum > 7'd31) ? 10'd31 : 10'(neg_sum);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sign_q      <= 1'b0;
            int_q       <= '0;
            frac_q      <= '0;
            exp_q       <= '0;
            dd_q        <= '0;
            of_q        <= 1'b0;
            nan_q       <= 1'b0;
            inf_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (inValid && in_ready_q) begin
                        opa_q      <= opA;
                        opb_q      <= opB;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        mcand_q    <= 22'(sig_a_in);
                        mplier_q   <= MW'(sig_b_in);
                        in_ready_q <= 1'b0;
                        state_q    <= (is_fast(opA) || is_fast(opB)) ? S_DONE : S_BUSY;
                    end
                end
                S_BUSY: begin
                    acc_q    <= acc_q + pp;
                    mcand_q  <= mcand_q << STEP;
                    mplier_q <= mplier_q >> STEP;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!out_valid_q) begin
                        sign_q      <= res_sign_d;
                        int_q       <= res_int_d;
                        frac_q      <= res_frac_d;
                        exp_q       <= res_exp_d;
                        dd_q        <= res_dd_d;
                        of_q        <= res_of_d;
                        nan_q       <= res_nan_d;
                        inf_q       <= res_inf_d;
                        out_valid_q <= 1'b1;
                    end else if (outReady) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign inReady    = in_ready_q;
    assign outValid   = out_valid_q;
    assign unnormSign = sign_q;
    assign unnormInt  = int_q;
    assign unnormFrac = frac_q;
    assign unnormExp  = exp_q;
    assign denormDiff = dd_q;
    assign sticky     = 1'b0;
    assign OFin       = of_q;
    assign isNaN      = nan_q;
    assign isInf      = inf_q;

endmodule

// File: tb/tb_fpu_mul16_sig_iter.sv
// Bench for fpu_mul16_sig_iter: STEP=1 and STEP=2 instances driven in lockstep,
// directed vectors, handshake corner sequences and random operands vs a reference model.

module tb_fpu_mul16_sig_iter;

    typedef struct packed {
        logic        sign;
        logic [1:0]  ii;
        logic [19:0] frac;
        logic [4:0]  exp;
        logic [9:0]  dd;
        logic        st;
        logic        of;
        logic        nan;
        logic        inf;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        bit          fast;
        res_t        r;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, inValid, outReady;
    logic [15:0] opA, opB;

    logic        in_ready1, out_valid1, s1, st1, of1, nan1, inf1;
    logic [1:0]  i1;
    logic [19:0] f1;
    logic [4:0]  e1;
    logic [9:0]  d1;
    logic        in_ready2, out_valid2, s2, st2, of2, nan2, inf2;
    logic [1:0]  i2;
    logic [19:0] f2;
    logic [4:0]  e2;
    logic [9:0]  d2;

    fpu_mul16_sig_iter #(.STEP(1), .PFW(20)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(in_ready1),
        .opA(opA), .opB(opB), .outValid(out_valid1), .outReady(outReady),
        .unnormSign(s1), .unnormInt(i1), .unnormFrac(f1), .unnormExp(e1),
        .denormDiff(d1), .sticky(st1), .OFin(of1), .isNaN(nan1), .isInf(inf1)
    );

    fpu_mul16_sig_iter #(.STEP(2), .PFW(20)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(in_ready2),
        .opA(opA), .opB(opB), .outValid(out_valid2), .outReady(outReady),
        .unnormSign(s2), .unnormInt(i2), .unnormFrac(f2), .unnormExp(e2),
        .denormDiff(d2), .sticky(st2), .OFin(of2), .isNaN(nan2), .isInf(inf2)
    );

    res_t r1, r2;
    always_comb begin
        r1 = '{sign: s1, ii: i1, frac: f1, exp: e1, dd: d1, st: st1, of: of1, nan: nan1, inf: inf1};
        r2 = '{sign: s2, ii: i2, frac: f2, exp: e2, dd: d2, st: st2, of: of2, nan: nan2, inf: inf2};
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmp_res(input string tag, input res_t a, input res_t e);
        chk({tag, " sign"},   32'(a.sign), 32'(e.sign));
        chk({tag, " int"},    32'(a.ii),   32'(e.ii));
        chk({tag, " frac"},   32'(a.frac), 32'(e.frac));
        chk({tag, " exp"},    32'(a.exp),  32'(e.exp));
        chk({tag, " ddiff"},  32'(a.dd),   32'(e.dd));
        chk({tag, " sticky"}, 32'(a.st),   32'(e.st));
        chk({tag, " OFin"},   32'(a.of),   32'(e.of));
        chk({tag, " isNaN"},  32'(a.nan),  32'(e.nan));
        chk({tag, " isInf"},  32'(a.inf),  32'(e.inf));
    endtask

    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int k = 0; k < e; k++) r = r * 2.0;
        else        for (int k = 0; k < -e; k++) r = r * 0.5;
        return r;
    endfunction

    function automatic real fp16_mag(input logic [15:0] x);
        if (x[14:10] == 5'd0) return real'(x[9:0]) * pow2(-24);
        return real'(1024 + int'(x[9:0])) * pow2(int'(x[14:10]) - 25);
    endfunction

    // Value represented by an unnormalized result: P * 2^-20 * 2^(E-15).
    function automatic real res_mag(input res_t r);
        int e;
        e = (r.exp != 5'd0) ? int'(r.exp) : -int'(r.dd);
        return real'({r.ii, r.frac}) * pow2(-20) * pow2(e - 15);
    endfunction

    function automatic bit is_fast(input logic [15:0] a, input logic [15:0] b);
        return (a[14:10] == 5'h1f) || (b[14:10] == 5'h1f) || (a[14:0] == 0) || (b[14:0] == 0);
    endfunction

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b);
        res_t r;
        int   ea, eb, sa, sb, sum;
        int   p;
        bit   za, zb, ia, ib, na, nb;
        r  = '0;
        za = (a[14:0] == 0);
        zb = (b[14:0] == 0);
        ia = (a[14:10] == 31) && (a[9:0] == 0);
        ib = (b[14:10] == 31) && (b[9:0] == 0);
        na = (a[14:10] == 31) && (a[9:0] != 0);
        nb = (b[14:10] == 31) && (b[9:0] != 0);
        if (na || nb || (ia && zb) || (ib && za)) begin
            r.nan = 1'b1;
        end else begin
            r.sign = a[15] ^ b[15];
            if (ia || ib) begin
                r.inf = 1'b1;
                r.of  = 1'b1;
            end else if (!(za || zb)) begin
                sa  = (a[14:10] == 0) ? int'(a[9:0]) : 1024 + int'(a[9:0]);
                sb  = (b[14:10] == 0) ? int'(b[9:0]) : 1024 + int'(b[9:0]);
                ea  = (a[14:10] == 0) ? 1 : int'(a[14:10]);
                eb  = (b[14:10] == 0) ? 1 : int'(b[14:10]);
                p   = sa * sb;
                sum = ea + eb - 15;
                if (sum >= 31) begin
                    r.of = 1'b1;
                end else begin
                    r.ii   = 2'(p / (1 << 20));
                    r.frac = 20'(p % (1 << 20));
                    if (sum >= 1) r.exp = 5'(sum);
                    else          r.dd  = 10'((-sum > 31) ? 31 : -sum);
                end
            end
        end
        return r;
    endfunction

    // Entered at the negedge following the accept edge; latency counted in edges.
    task automatic wait_both(input string tag, input int lat1, input int lat2, input res_t e);
        int l1 = -1;
        int l2 = -1;
        int cyc = 0;
        while ((l1 < 0 || l2 < 0) && cyc < 40) begin
            if (out_valid1 && l1 < 0) begin
                l1 = cyc;
                cmp_res({tag, " S1"}, r1, e);
            end
            if (out_valid2 && l2 < 0) begin
                l2 = cyc;
                cmp_res({tag, " S2"}, r2, e);
            end
            if (l1 < 0 || l2 < 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk({tag, " latency S1"}, 32'(l1), 32'(lat1));
        chk({tag, " latency S2"}, 32'(l2), 32'(lat2));
    endtask

    task automatic handoff(input string tag);
        outReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        outReady = 1'b0;
        chk({tag, " post outValid S1"}, 32'(out_valid1), 32'd0);
        chk({tag, " post outValid S2"}, 32'(out_valid2), 32'd0);
        chk({tag, " post inReady S1"},  32'(in_ready1),  32'd1);
        chk({tag, " post inReady S2"},  32'(in_ready2),  32'd1);
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input bit fast, input res_t e, input bit real_chk);
        opA = a;
        opB = b;
        inValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        wait_both(tag, fast ? 1 : 12, fast ? 1 : 7, e);
        if (real_chk) begin
            checks++;
            if (res_mag(r1) != fp16_mag(a) * fp16_mag(b)) begin
                errors++;
                $display("FAIL %s value: got %g expected %g", tag, res_mag(r1), fp16_mag(a) * fp16_mag(b));
            end
        end
        handoff(tag);
    endtask

    vec_t vecs[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        res_t zero_r, e;
        logic [15:0] a, b;
        zero_r = '0;

        vecs[0]  = '{16'h3C00, 16'h3C00, 1'b0, '{sign:0, ii:2'b01, frac:20'h00000, exp:15, dd:0,  st:0, of:0, nan:0, inf:0}};
        vecs[1]  = '{16'h3E00, 16'h3E00, 1'b0, '{sign:0, ii:2'b10, frac:20'h40000, exp:15, dd:0,  st:0, of:0, nan:0, inf:0}};
        vecs[2]  = '{16'h7BFF, 16'h7BFF, 1'b0, '{sign:0, ii:2'b00, frac:20'h00000, exp:0,  dd:0,  st:0, of:1, nan:0, inf:0}};
        vecs[3]  = '{16'h8001, 16'h3800, 1'b0, '{sign:1, ii:2'b00, frac:20'h00400, exp:0,  dd:0,  st:0, of:0, nan:0, inf:0}};
        vecs[4]  = '{16'h0001, 16'h0001, 1'b0, '{sign:0, ii:2'b00, frac:20'h00001, exp:0,  dd:13, st:0, of:0, nan:0, inf:0}};
        vecs[5]  = '{16'h7C00, 16'h0000, 1'b1, '{sign:0, ii:2'b00, frac:20'h00000, exp:0,  dd:0,  st:0, of:0, nan:1, inf:0}};
        vecs[6]  = '{16'hFC00, 16'h3C00, 1'b1, '{sign:1, ii:2'b00, frac:20'h00000, exp:0,  dd:0,  st:0, of:1, nan:0, inf:1}};
        vecs[7]  = '{16'h7E00, 16'h3C00, 1'b1, '{sign:0, ii:2'b00, frac:20'h00000, exp:0,  dd:0,  st:0, of:0, nan:1, inf:0}};
        vecs[8]  = '{16'h8000, 16'h3C00, 1'b1, '{sign:1, ii:2'b00, frac:20'h00000, exp:0,  dd:0,  st:0, of:0, nan:0, inf:0}};
        vecs[9]  = '{16'h4000, 16'h4000, 1'b0, '{sign:0, ii:2'b01, frac:20'h00000, exp:17, dd:0,  st:0, of:0, nan:0, inf:0}};
        vecs[10] = '{16'hC000, 16'h3C00, 1'b0, '{sign:1, ii:2'b01, frac:20'h00000, exp:16, dd:0,  st:0, of:0, nan:0, inf:0}};

        rst_n = 1'b0;
        inValid = 1'b0;
        outReady = 1'b0;
        opA = '0;
        opB = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset inReady S1", 32'(in_ready1), 32'd1);
        chk("reset inReady S2", 32'(in_ready2), 32'd1);
        chk("reset outValid S1", 32'(out_valid1), 32'd0);
        chk("reset outValid S2", 32'(out_valid2), 32'd0);
        cmp_res("reset S1", r1, zero_r);
        cmp_res("reset S2", r2, zero_r);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 11; v++) begin
            run_op($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].fast, vecs[v].r, 1'b0);
        end

        // Backpressure: result held while outReady low; a waiting op enters only after handoff.
        e = '{sign:0, ii:2'b01, frac:20'h80000, exp:15, dd:0, st:0, of:0, nan:0, inf:0};
        opA = 16'h3C00;
        opB = 16'h3E00;
        inValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        wait_both("bp first", 12, 7, e);
        opA = 16'h4000;
        opB = 16'hC000;
        inValid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            cmp_res($sformatf("bp hold%0d S1", k), r1, e);
            cmp_res($sformatf("bp hold%0d S2", k), r2, e);
            chk($sformatf("bp hold%0d outValid S1", k), 32'(out_valid1), 32'd1);
            chk($sformatf("bp hold%0d inReady S1", k), 32'(in_ready1), 32'd0);
            chk($sformatf("bp hold%0d inReady S2", k), 32'(in_ready2), 32'd0);
        end
        handoff("bp release");
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        e = '{sign:1, ii:2'b01, frac:20'h00000, exp:17, dd:0, st:0, of:0, nan:0, inf:0};
        wait_both("bp second", 12, 7, e);
        handoff("bp second");

        // Reset in BUSY after five updates discards the in-flight product.
        opA = 16'h3C00;
        opB = 16'h3C00;
        inValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midreset outValid S1", 32'(out_valid1), 32'd0);
        chk("midreset outValid S2", 32'(out_valid2), 32'd0);
        chk("midreset inReady S1", 32'(in_ready1), 32'd1);
        chk("midreset inReady S2", 32'(in_ready2), 32'd1);
        cmp_res("midreset S1", r1, zero_r);
        cmp_res("midreset S2", r2, zero_r);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("after reset", 16'h4000, 16'h4000, 1'b0,
               '{sign:0, ii:2'b01, frac:20'h00000, exp:17, dd:0, st:0, of:0, nan:0, inf:0}, 1'b1);

        for (int n = 0; n < 40; n++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (n % 3 == 0) a[14:10] = 5'($urandom_range(0, 2));
            if (n % 5 == 1) b[14:10] = 5'($urandom_range(24, 31));
            if (n % 7 == 2) b[14:0] = 15'd0;
            e = model(a, b);
            run_op($sformatf("rand%0d %h*%h", n, a, b), a, b, is_fast(a, b), e,
                   !is_fast(a, b) && !e.of);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
